// File: rtl/can_pkg.sv
// Shared CAN frame-tail definitions: bus levels, default field lengths and
// the state encoding of the ACK/EOF/intermission sequencer.
package can_pkg;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int EOF_BITS_DEFAULT = 7;
  localparam int IFS_BITS_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ACK_SLOT     = 3'd1,
    ST_ACK_DELIM    = 3'd2,
    ST_EOF          = 3'd3,
    ST_INTERMISSION = 3'd4
  } ack_eof_state_t;

endpackage

// File: rtl/ack_eof_field_if.sv
// Frame controller <-> ACK/EOF field stage signals.
// master = frame controller side, slave = the ack_eof_field block.
interface ack_eof_field_if;

  logic       enable;
  logic       sample_point;
  logic       crc_complete;
  logic       rx_bit;
  logic       tx_bit;
  logic       ack_received;
  logic       ack_error;
  logic       form_error;
  logic       overload_request;
  logic       sof_detected;
  logic [3:0] bit_counter;
  logic       frame_complete;

  modport master (
    output enable, sample_point, crc_complete, rx_bit,
    input  tx_bit, ack_received, ack_error, form_error, overload_request,
           sof_detected, bit_counter, frame_complete
  );

  modport slave (
    input  enable, sample_point, crc_complete, rx_bit,
    output tx_bit, ack_received, ack_error, form_error, overload_request,
           sof_detected, bit_counter, frame_complete
  );

endinterface

// File: rtl/ack_eof_field.sv
// Transmit-side frame tail: ACK slot, ACK delimiter, EOF and intermission.
// Only monitors the bus (always drives recessive) and reports the outcome.
//
// state           | meaning
// ----------------+-------------------------------------------------------
// ST_IDLE         | waiting for a rising edge of crc_complete
// ST_ACK_SLOT     | sampling the ACK slot, dominant = acknowledged
// ST_ACK_DELIM    | ACK delimiter, must be recessive
// ST_EOF          | EOF bits, dominant on last bit = overload, else form error
// ST_INTERMISSION | intermission, dominant on last bit = back-to-back SOF
module ack_eof_field
  import can_pkg::*;
#(
  parameter int EOF_BITS = EOF_BITS_DEFAULT,
  parameter int IFS_BITS = IFS_BITS_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  ack_eof_field_if.slave  bus
);

  localparam logic [3:0] EOF_LAST = 4'(EOF_BITS - 1);
  localparam logic [3:0] IFS_LAST = 4'(IFS_BITS - 1);

  ack_eof_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  // Inverted delayed copy of crc_complete: set only after crc_complete was
  // seen low, so clearing it on reset means a level still high afterwards
  // cannot start a frame until it drops and rises again.
  logic crc_arm_q, crc_arm_d;
  logic tx_bit_q, tx_bit_d;
  logic ack_q, ack_d;
  logic ack_err_q, ack_err_d;
  logic form_err_q, form_err_d;
  logic ovl_q, ovl_d;
  logic sof_q, sof_d;
  logic fc_q, fc_d;

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_arm_d  = ~bus.crc_complete;
    tx_bit_d   = RECESSIVE;
    ack_d      = ack_q;
    ack_err_d  = 1'b0;
    form_err_d = 1'b0;
    ovl_d      = 1'b0;
    sof_d      = 1'b0;
    fc_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (bus.crc_complete && crc_arm_q) begin
          state_d = ST_ACK_SLOT;
          ack_d   = 1'b0;
        end
      end
      ST_ACK_SLOT: if (bus.sample_point) begin
        if (bus.rx_bit == DOMINANT) begin
          ack_d   = 1'b1;
          state_d = ST_ACK_DELIM;
        end else begin
          ack_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ACK_DELIM: if (bus.sample_point) begin
        cnt_d = 4'd0;
        if (bus.rx_bit == DOMINANT) begin
          form_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_EOF;
        end
      end
      ST_EOF: if (bus.sample_point) begin
        if (bus.rx_bit == DOMINANT) begin
          if (cnt_q == EOF_LAST) ovl_d = 1'b1;
          else                   form_err_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == EOF_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_INTERMISSION;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_INTERMISSION: if (bus.sample_point) begin
        if (cnt_q == IFS_LAST) begin
          sof_d   = (bus.rx_bit == DOMINANT);
          fc_d    = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (bus.rx_bit == DOMINANT) begin
          ovl_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset or disable returns everything to idle.
  always_ff @(posedge clock) begin
    if (reset || !bus.enable) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      crc_arm_q  <= 1'b0;
      tx_bit_q   <= RECESSIVE;
      ack_q      <= 1'b0;
      ack_err_q  <= 1'b0;
      form_err_q <= 1'b0;
      ovl_q      <= 1'b0;
      sof_q      <= 1'b0;
      fc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_arm_q  <= crc_arm_d;
      tx_bit_q   <= tx_bit_d;
      ack_q      <= ack_d;
      ack_err_q  <= ack_err_d;
      form_err_q <= form_err_d;
      ovl_q      <= ovl_d;
      sof_q      <= sof_d;
      fc_q       <= fc_d;
    end
  end

  assign bus.tx_bit           = tx_bit_q;
  assign bus.ack_received     = ack_q;
  assign bus.ack_error        = ack_err_q;
  assign bus.form_error       = form_err_q;
  assign bus.overload_request = ovl_q;
  assign bus.sof_detected     = sof_q;
  assign bus.bit_counter      = cnt_q;
  assign bus.frame_complete   = fc_q;

endmodule

// File: tb/tb_ack_eof_field.sv
// Bench for ack_eof_field. The reference model tracks a frame only as
// "position of the current sample point after ACK_SLOT entry" and derives
// each outcome from which field that position falls in.
module tb_ack_eof_field;

  localparam int EOF_N    = 7;
  localparam int IFS_N    = 3;
  localparam int LAST_POS = 1 + EOF_N + IFS_N;

  logic clock = 1'b0;
  logic reset;
  ack_eof_field_if bus();

  ack_eof_field #(.EOF_BITS(EOF_N), .IFS_BITS(IFS_N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // model state
  bit m_active;
  bit m_armed;
  bit m_ack;
  int m_pos;
  logic e_ae, e_fe, e_ov, e_sof, e_fc;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // index of a frame position within EOF / intermission, 0 elsewhere
  function automatic int field_index(input int p);
    if (p >= 2 && p <= 1 + EOF_N) return p - 2;
    if (p >= 2 + EOF_N && p <= LAST_POS) return p - 2 - EOF_N;
    return 0;
  endfunction

  // one clock: update the model from the inputs currently applied, clock,
  // then compare every output one time unit after the edge
  task automatic step(input string tag);
    bit done;
    int p;
    {e_ae, e_fe, e_ov, e_sof, e_fc} = '0;
    if (reset || !bus.enable) begin
      m_active = 0; m_pos = 0; m_ack = 0; m_armed = 0;
    end else begin
      if (!m_active) begin
        if (bus.crc_complete && m_armed) begin
          m_active = 1; m_pos = 0; m_ack = 0;
        end
      end else if (bus.sample_point) begin
        p = m_pos;
        done = 1;
        if (p == 0) begin
          if (bus.rx_bit) e_ae = 1;
          else begin m_ack = 1; done = 0; end
        end else if (bus.rx_bit == 1'b0) begin
          if (p < 1 + EOF_N)       e_fe = 1;
          else if (p == 1 + EOF_N) e_ov = 1;
          else if (p < LAST_POS)   e_ov = 1;
          else begin e_sof = 1; e_fc = 1; end
        end else if (p == LAST_POS) begin
          e_fc = 1;
        end else begin
          done = 0;
        end
        if (done) begin m_active = 0; m_pos = 0; end
        else m_pos = p + 1;
      end
      m_armed = !bus.crc_complete;
    end
    @(posedge clock);
    #1;
    chk({tag, ".tx_bit"},    4'(bus.tx_bit),           4'd1);
    chk({tag, ".ack_rx"},    4'(bus.ack_received),     4'(m_ack));
    chk({tag, ".ack_err"},   4'(bus.ack_error),        4'(e_ae));
    chk({tag, ".form_err"},  4'(bus.form_error),       4'(e_fe));
    chk({tag, ".overload"},  4'(bus.overload_request), 4'(e_ov));
    chk({tag, ".sof"},       4'(bus.sof_detected),     4'(e_sof));
    chk({tag, ".frame_cpl"}, 4'(bus.frame_complete),   4'(e_fc));
    chk({tag, ".bit_cnt"},   bus.bit_counter,          4'(m_active ? field_index(m_pos) : 0));
  endtask

  // start a frame and feed nsp sample points (bit i = rx at position i),
  // with random gaps in which rx_bit (and optionally crc_complete) wanders
  task automatic run_frame(input string tag, input logic [11:0] bits, input int nsp,
                           input bit hold_crc, input bit wiggle_crc);
    bus.crc_complete = 1'b1;
    bus.sample_point = 1'b0;
    step({tag, ".start"});
    if (!hold_crc) bus.crc_complete = 1'b0;
    for (int i = 0; i < nsp; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.rx_bit = 1'($urandom);
        if (wiggle_crc) bus.crc_complete = 1'($urandom);
        step({tag, ".gap"});
      end
      bus.sample_point = 1'b1;
      bus.rx_bit       = bits[i];
      step({tag, ".sp"});
      bus.sample_point = 1'b0;
    end
    bus.rx_bit = 1'b1;
  endtask

  task automatic settle(input string tag);
    bus.crc_complete = 1'b0;
    bus.sample_point = 1'b0;
    bus.rx_bit       = 1'b1;
    repeat (3) step(tag);
  endtask

  initial begin
    logic [11:0] rbits;
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.sample_point = 1'b0;
    bus.crc_complete = 1'b0;
    bus.rx_bit       = 1'b1;
    m_active = 0; m_armed = 0; m_ack = 0; m_pos = 0;
    step("reset");
    step("reset");
    reset = 1'b0;
    step("idle");

    // 1 normal frame
    run_frame("normal", 12'hFFE, LAST_POS + 1, 0, 0);
    settle("normal.end");
    // 2 missing ACK
    run_frame("no_ack", 12'hFFF, LAST_POS + 1, 0, 0);
    settle("no_ack.end");
    // 3 form errors: ACK delimiter, EOF bit 3
    run_frame("form_delim", 12'hFFC, LAST_POS + 1, 0, 0);
    settle("form_delim.end");
    run_frame("form_eof3", 12'hFDE, LAST_POS + 1, 0, 0);
    settle("form_eof3.end");
    // 4 overload: EOF bit 6, intermission bit 1
    run_frame("ovl_eof6", 12'hEFE, LAST_POS + 1, 0, 0);
    settle("ovl_eof6.end");
    run_frame("ovl_ifs1", 12'hBFE, LAST_POS + 1, 0, 0);
    settle("ovl_ifs1.end");
    // 5 back-to-back SOF
    run_frame("sof", 12'h7FE, LAST_POS + 1, 0, 0);
    settle("sof.end");

    // 6A reset at EOF bit 4
    run_frame("rst_mid", 12'hFFE, 6, 0, 0);
    reset = 1'b1;
    bus.sample_point = 1'b1;
    step("rst_mid.reset");
    reset = 1'b0;
    bus.sample_point = 1'b0;
    settle("rst_mid.after");

    // 6B crc_complete held high across reset: no restart
    run_frame("rst_hold", 12'hFFE, 6, 1, 0);
    reset = 1'b1;
    step("rst_hold.reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sample_point = 1'b1;
      bus.rx_bit       = 1'b0;
      step("rst_hold.no_restart");
    end
    bus.sample_point = 1'b0;
    bus.crc_complete = 1'b0;
    step("rst_hold.low");
    run_frame("rst_hold.again", 12'hFFE, LAST_POS + 1, 0, 0);
    settle("rst_hold.end");

    // 6C enable dropped mid-field
    run_frame("en_mid", 12'hFFE, 8, 0, 0);
    bus.enable = 1'b0;
    bus.sample_point = 1'b1;
    step("en_mid.disable");
    bus.enable = 1'b1;
    bus.sample_point = 1'b0;
    settle("en_mid.after");

    // randomized frames, some with crc_complete toggling mid-frame
    for (int n = 0; n < 30; n++) begin
      rbits = 12'hFFF;
      rbits[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0)
        rbits[$urandom_range(1, LAST_POS)] = 1'b0;
      run_frame("rand", rbits, LAST_POS + 1, 0, 1'($urandom));
      settle("rand.end");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ack_eof_field.md
Name: ack_eof_field

Overview:
- Transmit-side frame tail stage that sits directly downstream of the CRC field.
- Starts when the CRC field signals completion, then drives and monitors four fields in order: ACK slot, ACK delimiter, End-of-Frame (EOF) and Intermission.
- Reports acknowledge status, form errors, overload conditions and frame completion to the frame controller.
- No bit stuffing applies to these fields, so the block ignores the stuff-bit indication entirely.

Parameters:
- EOF_BITS, 7, number of recessive EOF bits.
- IFS_BITS, 3, number of intermission bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low forces IDLE and reset outputs on the next edge.
- sample_point  in  1  one-cycle bit sample strobe.
- crc_complete  in  1  level from the CRC field; high once the CRC delimiter has been sampled.
- rx_bit  in  1  bus value at the sample point (0 = dominant).
- tx_bit  out  1  bit driven to the bus; always 1 (recessive) from this block.
- ack_received  out  1  registered; 1 once a dominant ACK slot has been sampled.
- ack_error  out  1  one-cycle pulse.
- form_error  out  1  one-cycle pulse.
- overload_request  out  1  one-cycle pulse.
- sof_detected  out  1  one-cycle pulse; dominant seen in the last intermission bit.
- bit_counter  out  4  index of the current bit within EOF or Intermission.
- frame_complete  out  1  one-cycle pulse at the end of Intermission.

Behaviour:
- Reset (reset=1 or enable=0, synchronous):
  - state=IDLE, tx_bit=1, ack_received=0, all pulses=0, bit_counter=0.
  - crc_complete edge register cleared.
  - This applies mid-field as well: there is no residual pulse after reset.
- tx_bit is 1 in every state. It is registered only for uniform timing.
- States: IDLE, ACK_SLOT, ACK_DELIM, EOF, INTERMISSION.
- IDLE -> ACK_SLOT:
  - Taken on the cycle after a 0->1 edge of crc_complete, detected via an internal delayed copy.
  - A level held high does not retrigger.
- ACK_SLOT, at sample_point:
  - rx_bit=0: ack_received<=1, go to ACK_DELIM.
  - rx_bit=1: ack_error pulse, ack_received stays 0, go to IDLE.
- ACK_DELIM, at sample_point:
  - rx_bit=0: form_error pulse, go to IDLE.
  - Otherwise: bit_counter<=0, go to EOF.
- EOF, at each sample_point with index = bit_counter:
  - rx_bit=0 and index<EOF_BITS-1: form_error pulse, go to IDLE.
  - rx_bit=0 and index=EOF_BITS-1: overload_request pulse, go to IDLE.
  - Otherwise: bit_counter increments. After index EOF_BITS-1 it wraps to 0 and the state goes to INTERMISSION.
- INTERMISSION, at each sample_point:
  - rx_bit=0 and index<IFS_BITS-1: overload_request pulse, go to IDLE.
  - rx_bit=0 and index=IFS_BITS-1: sof_detected pulse and frame_complete pulse together, go to IDLE.
  - Recessive on the last bit: frame_complete pulse, go to IDLE.
  - Recessive on other bits: bit_counter increments.
- Timing and counter rules:
  - Any state is held without change while sample_point=0.
  - All pulses are asserted for exactly one cycle, on the edge following the sample_point cycle.
  - bit_counter=0 outside EOF and INTERMISSION.
  - ack_received holds until the next IDLE->ACK_SLOT entry, where it is cleared, or until reset.
- Simultaneous events:
  - reset or enable=0 overrides sample_point.
  - A crc_complete edge arriving while not in IDLE is ignored.
- Latency: frame_complete fires 2+EOF_BITS+IFS_BITS sample points after ACK_SLOT entry.

Decomposition:
- Shared can_pkg holds:
  - DOMINANT=1'b0 and RECESSIVE=1'b1 constants.
  - EOF_BITS_DEFAULT and IFS_BITS_DEFAULT.
  - The ack_eof_state_t enum (3-bit encoding).
- No sub-module: one FSM with a shared 4-bit counter fits in a single module.

Test Plan:
1. Normal frame:
   - Stimulus: crc_complete rises; rx_bit=0 at the ACK slot, then 1 for all later bits.
   - Required: ack_received=1; frame_complete pulses at the 12th sample point after ACK_SLOT entry; no error pulses.
2. Missing ACK:
   - Stimulus: rx_bit=1 at the ACK slot.
   - Required: ack_error pulses once, ack_received=0, state returns to IDLE, frame_complete never fires.
3. Form errors:
   - Stimulus A: rx_bit=0 at the ACK delimiter. Required: one form_error pulse.
   - Stimulus B: rx_bit=0 at EOF bit_counter=3. Required: one form_error pulse, bit_counter returns to 0.
4. Overload:
   - Stimulus A: rx_bit=0 at EOF bit 6. Required: overload_request pulse, no form_error.
   - Stimulus B: rx_bit=0 at intermission bit 1. Required: overload_request pulse.
5. Back-to-back SOF:
   - Stimulus: rx_bit=0 at intermission bit 2.
   - Required: sof_detected and frame_complete pulse on the same cycle.
6. Reset and enable mid-field:
   - Stimulus A: reset=1 at EOF bit 4. Required: IDLE on the next edge, all outputs at reset values.
   - Stimulus B: crc_complete held high across the reset. Required: no restart until crc_complete goes low, then high again.
   - Stimulus C: enable=0 mid-field. Required: same result as the reset.
